lorenz_decrypt: RTL
===================

Name: lorenz_decrypt

Overview:
- Inverse of the chaotic-map image cipher: undoes confusion (z key), then diffusion (y key), then confusion (x key), in place, on a single-port image RAM.
- Key RAMs hold the 16-bit words generated by the Lorenz trajectory engine.
- Sits beside the encryptor on the same image RAM and key RAMs. It is started by the host after key generation and after ciphertext load.
- Forward cipher, for reference:
  - confusion(k): for i = 0..N-1, swap img[i] and img[k[i]].
  - diffusion: img[i] ^= y[i].

Parameters:
- ADDR_W, 16, image/key address width; N = 2^ADDR_W words.
- DATA_W, 16, image and key word width; must be >= ADDR_W.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- start  in  1  one-cycle request; accepted only in IDLE
- busy  out  1  high while a decryption pass is running
- done  out  1  one-cycle pulse at completion
- phase  out  2  0 = idle/done, 1 = unconfuse-z, 2 = undiffuse-y, 3 = unconfuse-x
- key_addr  out  ADDR_W  shared read address to the x, y and z key RAMs
- kx_q, ky_q, kz_q  in  DATA_W each  key RAM read data; 1-cycle read latency
- img_addr  out  ADDR_W  image RAM address
- img_re  out  1  image read enable; data valid next cycle
- img_rdata  in  DATA_W  image read data
- img_we  out  1  image write enable
- img_wdata  out  DATA_W  image write data

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset values: busy, done, img_re, img_we, key_addr, img_addr, img_wdata = 0; phase = 0; state = IDLE.
- Reset mid-pass: return to IDLE next edge with no further RAM writes. Image content is then partial/undefined.
- IDLE: start = 1 at edge T moves to the Z phase. busy = 1 from cycle T+1. Index i = N-1 (descending).
- Swap phases (Z: key = kz_q, i from N-1 down to 0; X: key = kx_q, same order). Six cycles per index:
  - K_ISSUE: key_addr = i.
  - RD_I: j <= key[ADDR_W-1:0]; img_addr = i; img_re = 1.
  - RD_J: a <= img_rdata; img_addr = j; img_re = 1.
  - CAP_J: b <= img_rdata.
  - WR_I: img_we = 1; addr i; wdata b.
  - WR_J: img_we = 1; addr j; wdata a.
  - Then i == 0 advances to the next phase; otherwise i <= i-1, back to K_ISSUE.
- j == i: both writes still issue; the value is unchanged.
- Key upper bits above ADDR_W are ignored.
- Y phase: i from 0 up to N-1. Three cycles per index:
  - K_ISSUE: key_addr = i.
  - RD: img_addr = i; img_re = 1; kyv <= ky_q.
  - WR: img_we = 1; addr i; wdata = img_rdata ^ kyv.
  - i == N-1 advances to the X phase with i = N-1.
- Phase order is Z -> Y -> X -> DONE.
- DONE: one cycle with done = 1, busy = 0, phase = 0, then IDLE.
- Latency: start edge to done cycle = 15*N + 1 cycles.
- start while busy or in DONE is ignored, not queued.
- img_re and img_we are never both high.
- Outside RD/WR cycles: img_re = img_we = 0. img_addr and img_wdata hold their last values.
- Index counter is ADDR_W+1 bits wide internally so N-1 and 0 terminate cleanly; no wrap past 0 or N-1.

Decomposition:
- Shared package lorenz_pkg holds:
  - phase codes PH_IDLE/PH_Z/PH_Y/PH_X;
  - the state enum (IDLE, K_ISSUE, RD_I, RD_J, CAP_J, WR_I, WR_J, RD, WR, DONE);
  - default ADDR_W/DATA_W;
  - the FPU op codes and Lorenz constants already used by the generator.
- One sub-module, lorenz_swap_step, is natural. It performs the 6-cycle swap of one index given the key word, with a step/ack handshake, and is reused for both the Z and X phases.

Test Plan (ADDR_W = 3, N = 8; bench reference model = forward cipher):
- x[i] = z[i] = i, y = 0, img = 0x10..0x17 -> image unchanged; done at exactly 121 cycles after start; busy high for cycles 1..120.
- x[i] = z[i] = i, y[i] = 0xFFFF, img[i] = i -> img[i] = ~i (0xFFFF, 0xFFFE, ..., 0xFFF8).
- z[i] = 0, x[i] = i, y = 0, img = a0..a7 -> img = a1, a2, ..., a7, a0 (rotate left by 1).
- Random x/y/z keys (upper bits set) and random plaintext, encrypted by the model, then decrypted -> matches plaintext exactly; 100 seeds.
- reset asserted during Y phase (cycle 60) -> next cycle all outputs 0, no img_we afterwards; a fresh start then completes a full pass correctly.
- start pulsed at cycles 5 and 50 while busy -> ignored; exactly one done pulse at cycle 121.

Source files
------------

// File: rtl/lorenz_pkg.sv
// Shared definitions for the Lorenz chaotic-map cipher blocks: phase codes,
// controller states, default widths and the trajectory engine's FPU constants.
package lorenz_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_Z    = 2'd1;
    localparam logic [1:0] PH_Y    = 2'd2;
    localparam logic [1:0] PH_X    = 2'd3;

    typedef enum logic [3:0] {
        IDLE,
        K_ISSUE,
        RD_I,
        RD_J,
        CAP_J,
        WR_I,
        WR_J,
        RD,
        WR,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        FPU_ADD,
        FPU_SUB,
        FPU_MUL,
        FPU_NOP
    } fpu_op_t;

    // IEEE-754 single-precision constants used by the trajectory generator
    localparam logic [31:0] LORENZ_SIGMA = 32'h4120_0000;
    localparam logic [31:0] LORENZ_RHO   = 32'h41E0_0000;
    localparam logic [31:0] LORENZ_BETA  = 32'h402A_AAAB;
    localparam logic [31:0] LORENZ_DT    = 32'h3C23_D70A;

endpackage

// File: rtl/lorenz_decrypt_if.sv
// Host, key-RAM and image-RAM signals of the decryptor; master is the
// decryptor side, slave is the host/RAM side.
interface lorenz_decrypt_if
    import lorenz_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              start;
    logic              busy;
    logic              done;
    logic [1:0]        phase;
    logic [ADDR_W-1:0] key_addr;
    logic [DATA_W-1:0] kx_q;
    logic [DATA_W-1:0] ky_q;
    logic [DATA_W-1:0] kz_q;
    logic [ADDR_W-1:0] img_addr;
    logic              img_re;
    logic [DATA_W-1:0] img_rdata;
    logic              img_we;
    logic [DATA_W-1:0] img_wdata;

    modport master (
        input  start, kx_q, ky_q, kz_q, img_rdata,
        output busy, done, phase, key_addr, img_addr, img_re, img_we, img_wdata
    );

    modport slave (
        output start, kx_q, ky_q, kz_q, img_rdata,
        input  busy, done, phase, key_addr, img_addr, img_re, img_we, img_wdata
    );

endinterface

// File: rtl/lorenz_swap_step.sv
// Swaps img[idx] and img[key mod N] in five cycles after a one-cycle step
// request; ack marks the final write. Shared by the Z and X unconfusion passes.
module lorenz_swap_step
    import lorenz_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] key,
    input  logic [DATA_W-1:0] img_rdata,
    output logic              ack,
    output logic              img_re,
    output logic              img_we,
    output logic [ADDR_W-1:0] img_addr,
    output logic [DATA_W-1:0] img_wdata
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] j;
    logic [DATA_W-1:0] a, b;
    logic              unused_key_hi;

    assign unused_key_hi = ^key;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            j     <= '0;
            a     <= '0;
            b     <= '0;
        end else begin
            state <= state_n;
            if (state == RD_I)  j <= key[ADDR_W-1:0];
            if (state == RD_J)  a <= img_rdata;
            if (state == CAP_J) b <= img_rdata;
        end
    end

    always_comb begin
        state_n   = state;
        ack       = 1'b0;
        img_re    = 1'b0;
        img_we    = 1'b0;
        img_addr  = idx;
        img_wdata = b;
        case (state)
            IDLE:  if (step) state_n = RD_I;
            RD_I:  begin img_re = 1'b1; img_addr = idx; state_n = RD_J; end
            RD_J:  begin img_re = 1'b1; img_addr = j; state_n = CAP_J; end
            CAP_J: state_n = WR_I;
            WR_I:  begin img_we = 1'b1; img_addr = idx; img_wdata = b; state_n = WR_J; end
            WR_J:  begin
                img_we    = 1'b1;
                img_addr  = j;
                img_wdata = a;
                ack       = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/lorenz_decrypt.sv
// In-place decryptor: unconfuse with z (descending), undo XOR diffusion
// with y (ascending), then unconfuse with x (descending).
module lorenz_decrypt
    import lorenz_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic              clk,
    input logic              reset,
    lorenz_decrypt_if.master bus
);

    localparam int              N    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(N - 1);

    state_t            state, state_n;
    logic [1:0]        phase_q, phase_n;
    logic [ADDR_W:0]   idx, idx_n;
    logic [DATA_W-1:0] kyv;
    logic [ADDR_W-1:0] addr_hold, addr_out;
    logic [DATA_W-1:0] wdata_hold, wdata_out;
    logic              re_out, we_out;

    logic              step, swap_ack, swap_re, swap_we;
    logic [ADDR_W-1:0] swap_addr;
    logic [DATA_W-1:0] swap_wdata, swap_key;

    assign swap_key = (phase_q == PH_X) ? bus.kx_q : bus.kz_q;

    lorenz_swap_step #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_swap (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .idx       (idx[ADDR_W-1:0]),
        .key       (swap_key),
        .img_rdata (bus.img_rdata),
        .ack       (swap_ack),
        .img_re    (swap_re),
        .img_we    (swap_we),
        .img_addr  (swap_addr),
        .img_wdata (swap_wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            phase_q    <= PH_IDLE;
            idx        <= '0;
            kyv        <= '0;
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            state      <= state_n;
            phase_q    <= phase_n;
            idx        <= idx_n;
            addr_hold  <= addr_out;
            wdata_hold <= wdata_out;
            if (state == RD) kyv <= bus.ky_q;
        end
    end

    // During a swap the top parks in RD_I while the sub-module walks RD_I..WR_J
    always_comb begin
        state_n = state;
        phase_n = phase_q;
        idx_n   = idx;
        step    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = K_ISSUE;
                    phase_n = PH_Z;
                    idx_n   = LAST;
                end
            end
            K_ISSUE: begin
                if (phase_q == PH_Y) begin
                    state_n = RD;
                end else begin
                    step    = 1'b1;
                    state_n = RD_I;
                end
            end
            RD_I: begin
                if (swap_ack) begin
                    state_n = K_ISSUE;
                    if (idx != '0) begin
                        idx_n = idx - 1'b1;
                    end else if (phase_q == PH_Z) begin
                        phase_n = PH_Y;
                        idx_n   = '0;
                    end else begin
                        phase_n = PH_IDLE;
                        state_n = DONE;
                    end
                end
            end
            RD: state_n = WR;
            WR: begin
                state_n = K_ISSUE;
                if (idx == LAST) begin
                    phase_n = PH_X;
                    idx_n   = LAST;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Address and write data hold their last driven values when idle
    always_comb begin
        re_out    = swap_re;
        we_out    = swap_we;
        addr_out  = addr_hold;
        wdata_out = wdata_hold;
        if (swap_re || swap_we) addr_out = swap_addr;
        if (swap_we) wdata_out = swap_wdata;
        if (state == RD) begin
            re_out   = 1'b1;
            addr_out = idx[ADDR_W-1:0];
        end
        if (state == WR) begin
            we_out    = 1'b1;
            addr_out  = idx[ADDR_W-1:0];
            wdata_out = bus.img_rdata ^ kyv;
        end
    end

    assign bus.busy      = (state != IDLE) && (state != DONE);
    assign bus.done      = (state == DONE);
    assign bus.phase     = phase_q;
    assign bus.key_addr  = idx[ADDR_W-1:0];
    assign bus.img_re    = re_out;
    assign bus.img_we    = we_out;
    assign bus.img_addr  = addr_out;
    assign bus.img_wdata = wdata_out;

endmodule
